vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing downstream of the display-mode state machine. It counts pixels and lines and produces registered hsync, vsync, data-enable and active-area pixel coordinates. It also latches the 2-bit display mode once per frame, so the pattern generators never see a mode change mid-frame. It consumes the mode-FSM `state_out` on `mode_in` and feeds the bar, character and custom pattern generators.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
- sys_clk  input  1  pixel clock; single clock domain
- sys_rst  input  1  asynchronous reset, active-high
- mode_in  input  2  display mode from the mode FSM (0 idle, 1 bar, 2 char, 3 custom)
- hsync  output  1  horizontal sync, level set by SYNC_POL
- vsync  output  1  vertical sync, level set by SYNC_POL
- de  output  1  high when the pixel is in the visible area
- pix_x  output  12  visible-area column; 0 when de=0
- pix_y  output  12  visible-area row; 0 when the line is outside the visible area
- frame_start  output  1  one-cycle pulse on pixel (0,0)
- mode_frame  output  2  mode in force for the current frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All totals must be at most 4096.
- Internal counters are h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), both 12 bits, both reset to 0.
- h_cnt increments every cycle and wraps from H_TOTAL-1 to 0.
- v_cnt increments only when h_cnt wraps. v_cnt wraps from V_TOTAL-1 to 0 on the same edge that h_cnt wraps.
- Region order per line: active, then front porch, then sync, then back porch. The same order applies per frame, in lines.
- Each cycle, all outputs are registered decodes of the current (h_cnt, v_cnt):
  - h_act = h_cnt < H_ACTIVE
  - v_act = v_cnt < V_ACTIVE
  - de = h_act & v_act
  - pix_x = h_act ? h_cnt : 0
  - pix_y = v_act ? v_cnt : 0
  - hsync is at the active level when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync is at the active level when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync edges therefore align with the line start (h_cnt=0).
  - frame_start = (h_cnt==0 && v_cnt==0)
- Mode latch:
  - mode_frame <= mode_in only on the edge that registers frame_start=1. mode_frame otherwise holds its value.
  - Changes on mode_in between frame starts are ignored.
  - mode_in is not synchronised internally; it is already in the sys_clk domain.
  - All four mode values are passed through unmodified.

## Timing
- Reset values, applied immediately on sys_rst with no clock needed:
  - h_cnt = v_cnt = 0
  - hsync = vsync = !SYNC_POL (inactive)
  - de = 0, pix_x = 0, pix_y = 0
  - frame_start = 0, mode_frame = 0
- Latency: the outputs after edge k reflect the counter value held before edge k, so there is one cycle of latency from counter to pin. All outputs share this latency and stay mutually aligned.
- The first edge after reset release registers pixel (0,0): frame_start=1, de=1, pix_x=pix_y=0. mode_frame takes mode_in sampled on that same edge.
- frame_start period is H_TOTAL×V_TOTAL cycles (420000). Its pulse width is exactly 1 cycle.
- Reset asserted mid-frame aborts the frame. Outputs go to their reset values asynchronously, and the sequence restarts from pixel (0,0) as above.
- mode_in changing on the same edge as frame_start: the value sampled on that edge takes effect.

## Test plan
- Reset behaviour: hold sys_rst high for 5 cycles, then release.
  - During reset: hsync=vsync=1, de=0, frame_start=0, mode_frame=0.
  - First edge after release: frame_start=1, de=1, pix_x=0, pix_y=0.
- Horizontal timing, edges counted from release (edge 1 registers pixel 0,0):
  - de=1 for edges 1..640; de=0 and pix_x=0 from edge 641.
  - hsync=0 for edges 657..752; hsync=1 at edge 753.
  - Edge 801 registers pix_x=0, pix_y=1, de=1.
- Frame timing:
  - frame_start pulses at edges 1 and 420001 only.
  - 307200 de-high cycles per frame.
  - vsync low for exactly 1600 cycles, starting at edge 490×800+1.
- Mode latch:
  - Set mode_in=0 at reset release, switch to 2 at edge 1000: mode_frame stays 0 until edge 420001, then becomes 2.
  - A mode_in pulse to 1 for 3 cycles mid-frame is never seen on mode_frame.
- Mid-frame reset: assert sys_rst between edges 5000 and 5001.
  - Outputs take reset values without waiting for a clock.
  - After release, the next edge gives frame_start=1, pix_x=pix_y=0.
- Polarity: SYNC_POL=1 gives hsync/vsync reset value 0 and active-high pulses at the same edges as the horizontal and frame timing scenarios.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Counts pixels and lines, and produces registered hsync, vsync, data-enable
// and visible-area pixel coordinates. The display mode is latched once per
// frame so downstream pattern generators never see a mid-frame mode change.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode_in,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic [1:0]  mode_frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HLast = 12'(H_TOTAL - 1);
  localparam logic [11:0] VLast = 12'(V_TOTAL - 1);

  // Region bounds are 13 bits wide so a sync window ending exactly at 4096
  // still compares correctly against a 12-bit counter.
  localparam logic [12:0] HActEnd  = 13'(H_ACTIVE);
  localparam logic [12:0] HSyncBeg = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HSyncEnd = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VActEnd  = 13'(V_ACTIVE);
  localparam logic [12:0] VSyncBeg = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VSyncEnd = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap, v_wrap;

  logic [12:0] h_ext, v_ext;
  logic        h_act, v_act;
  logic        h_sync_win, v_sync_win;

  logic        hsync_d, vsync_d, de_d, frame_start_d;
  logic [11:0] pix_x_d, pix_y_d;

  // Counter next state: h wraps every line, v advances only on h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    v_wrap  = (v_cnt_q == VLast);
    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  // Decode the current counter position into next-cycle output values.
  always_comb begin
    h_ext         = {1'b0, h_cnt_q};
    v_ext         = {1'b0, v_cnt_q};
    h_act         = (h_ext < HActEnd);
    v_act         = (v_ext < VActEnd);
    h_sync_win    = (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
    v_sync_win    = (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);
    de_d          = h_act & v_act;
    pix_x_d       = h_act ? h_cnt_q : 12'd0;
    pix_y_d       = v_act ? v_cnt_q : 12'd0;
    hsync_d       = h_sync_win ? SYNC_POL : ~SYNC_POL;
    vsync_d       = v_sync_win ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

  // Pixel and line counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Registered timing outputs, one cycle behind the counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      frame_start <= frame_start_d;
    end
  end

  // Mode is captured only on the edge that registers frame_start.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_frame <= 2'd0;
    end else if (frame_start_d) begin
      mode_frame <= mode_in;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance of each sync polarity plus
// a scaled-down instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } exp_t;

  // Scaled-down geometry: 32 pixels x 21 lines = 672 cycles per frame.
  localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 5;
  localparam int SVA = 12, SVF = 2, SVS = 3, SVB = 4;
  localparam int F_BIG = 800 * 525;
  localparam int F_SM  = 32 * 21;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] mode_in;

  logic        hs0, vs0, de0, fs0;
  logic [11:0] x0, y0;
  logic [1:0]  mf0;
  logic        hs1, vs1, de1, fs1;
  logic [11:0] x1, y1;
  logic [1:0]  mf1;
  logic        hs2, vs2, de2, fs2;
  logic [11:0] x2, y2;
  logic [1:0]  mf2;

  int checks = 0;
  int errors = 0;
  int n = 0;  // edges since reset release; 0 while in reset
  logic [1:0] emode0 = 2'd0, emode1 = 2'd0, emode2 = 2'd0;
  int de_cnt = 0, vs_cnt = 0, vs_first = 0;

  always #5 sys_clk = ~sys_clk;

  vga_timing_gen #(.SYNC_POL(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_in(mode_in),
    .hsync(hs0), .vsync(vs0), .de(de0), .pix_x(x0), .pix_y(y0),
    .frame_start(fs0), .mode_frame(mf0)
  );

  vga_timing_gen #(.SYNC_POL(1'b1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_in(mode_in),
    .hsync(hs1), .vsync(vs1), .de(de1), .pix_x(x1), .pix_y(y1),
    .frame_start(fs1), .mode_frame(mf1)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0)
  ) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode_in(mode_in),
    .hsync(hs2), .vsync(vs2), .de(de2), .pix_x(x2), .pix_y(y2),
    .frame_start(fs2), .mode_frame(mf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // Expected outputs after n edges since release, from raster position alone.
  function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit pol, input int edges);
    exp_t e;
    int ht, vt, p, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (edges == 0) begin
      e = '{hs: !pol, vs: !pol, de: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0};
      return e;
    end
    p    = (edges - 1) % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    e.de = (x < ha) && (y < va);
    e.x  = (x < ha) ? 12'(x) : 12'd0;
    e.y  = (y < va) ? 12'(y) : 12'd0;
    e.hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : !pol;
    e.vs = (y >= va + vf && y < va + vf + vsw) ? pol : !pol;
    e.fs = (p == 0);
    return e;
  endfunction

  task automatic chk_dut(input string tag, input exp_t e, input logic hs, input logic vs,
                         input logic de, input logic [11:0] x, input logic [11:0] y,
                         input logic fs, input logic [1:0] mf, input logic [1:0] em);
    chk({tag, ".hsync"}, hs, e.hs);
    chk({tag, ".vsync"}, vs, e.vs);
    chk({tag, ".de"}, de, e.de);
    chk({tag, ".pix_x"}, x, e.x);
    chk({tag, ".pix_y"}, y, e.y);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".mode_frame"}, mf, em);
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after each edge.
  always @(posedge sys_clk) begin
    logic [1:0] m_now;
    m_now = mode_in;
    if (sys_rst) begin
      n      = 0;
      emode0 = 2'd0;
      emode1 = 2'd0;
      emode2 = 2'd0;
    end else begin
      n++;
      if (((n - 1) % F_BIG) == 0) begin
        emode0 = m_now;
        emode1 = m_now;
      end
      if (((n - 1) % F_SM) == 0) emode2 = m_now;
    end
    #1;
    chk_dut("dut0", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n),
            hs0, vs0, de0, x0, y0, fs0, mf0, emode0);
    chk_dut("dut1", model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, n),
            hs1, vs1, de1, x1, y1, fs1, mf1, emode1);
    chk_dut("dut2", model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, n),
            hs2, vs2, de2, x2, y2, fs2, mf2, emode2);
    // Second frame of the small instance: edges 673..1344.
    if (!sys_rst && n >= 673 && n <= 1344) begin
      if (de2) de_cnt++;
      if (!vs2) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = n;
      end
    end
  end

  task automatic at_edge(input int k);
    wait (n == k);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    mode_in = 2'd0;
    repeat (5) @(negedge sys_clk);
    chk("rst.hsync0", hs0, 1'b1);
    chk("rst.vsync0", vs0, 1'b1);
    chk("rst.de0", de0, 1'b0);
    chk("rst.fs0", fs0, 1'b0);
    chk("rst.mf0", mf0, 2'd0);
    chk("rst.hsync1", hs1, 1'b0);
    chk("rst.vsync1", vs1, 1'b0);
    sys_rst = 1'b0;

    at_edge(1);
    chk("e1.fs0", fs0, 1'b1);
    chk("e1.de0", de0, 1'b1);
    chk("e1.x0", x0, 12'd0);
    chk("e1.y0", y0, 12'd0);
    chk("e1.fs2", fs2, 1'b1);
    chk("e1.mf2", mf2, 2'd0);
    at_edge(100);
    mode_in = 2'd2;
    at_edge(640);
    chk("e640.de0", de0, 1'b1);
    chk("e640.x0", x0, 12'd639);
    at_edge(641);
    chk("e641.de0", de0, 1'b0);
    chk("e641.x0", x0, 12'd0);
    at_edge(656);
    chk("e656.hs0", hs0, 1'b1);
    chk("e656.hs1", hs1, 1'b0);
    at_edge(657);
    chk("e657.hs0", hs0, 1'b0);
    chk("e657.hs1", hs1, 1'b1);
    at_edge(672);
    chk("e672.mf2", mf2, 2'd0);
    at_edge(673);
    chk("e673.fs2", fs2, 1'b1);
    chk("e673.mf2", mf2, 2'd2);
    chk("e673.mf0", mf0, 2'd0);
    at_edge(752);
    chk("e752.hs0", hs0, 1'b0);
    at_edge(753);
    chk("e753.hs0", hs0, 1'b1);
    chk("e753.hs1", hs1, 1'b0);
    at_edge(801);
    chk("e801.x0", x0, 12'd0);
    chk("e801.y0", y0, 12'd1);
    chk("e801.de0", de0, 1'b1);
    // Three-cycle mid-frame pulse that must never reach mode_frame.
    at_edge(900);
    mode_in = 2'd1;
    at_edge(903);
    mode_in = 2'd2;
    at_edge(1345);
    chk("e1345.fs2", fs2, 1'b1);
    chk("e1345.mf2", mf2, 2'd2);
    chk("frame2.de_cnt", de_cnt, 240);
    chk("frame2.vs_cnt", vs_cnt, 96);
    chk("frame2.vs_first", vs_first, 1121);

    // Mid-frame reset between edges 5000 and 5001.
    at_edge(5000);
    sys_rst = 1'b1;
    #1;
    chk("arst.hs0", hs0, 1'b1);
    chk("arst.vs0", vs0, 1'b1);
    chk("arst.de0", de0, 1'b0);
    chk("arst.x0", x0, 12'd0);
    chk("arst.fs0", fs0, 1'b0);
    chk("arst.hs1", hs1, 1'b0);
    chk("arst.mf2", mf2, 2'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    at_edge(1);
    chk("rel.fs0", fs0, 1'b1);
    chk("rel.x0", x0, 12'd0);
    chk("rel.y0", y0, 12'd0);
    chk("rel.fs2", fs2, 1'b1);
    chk("rel.mf2", mf2, 2'd2);
    at_edge(1400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
